// File: rtl/add_level_sched.sv
// One pairwise-add level of the adder tree, time-multiplexed over NUM_ADD shared adders.
// Define ADD_LEVEL_SCHED_STATS_EN to add the job_cnt / stall_cnt counter ports.
module add_level_sched #(
    parameter int IN_W    = 5,
    parameter int N_IN    = 64,
    parameter int NUM_ADD = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_IN*IN_W-1:0]            in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [(N_IN/2)*(IN_W+1)-1:0]    out_data,
    output logic                            busy
`ifdef ADD_LEVEL_SCHED_STATS_EN
    ,
    output logic [15:0]                     job_cnt,
    output logic [15:0]                     stall_cnt
`endif
);
    localparam int G     = N_IN / (2 * NUM_ADD);
    localparam int IDX_W = (G > 1) ? $clog2(G) : 1;
    localparam int SW    = IN_W + 1;
    localparam int NS    = N_IN / 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(G - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_IN*IN_W-1:0]   op_q, op_d;
    logic [NS*SW-1:0]       res_q, res_d;
    logic [NUM_ADD-1:0][SW-1:0] add_sum;

    // Adder j always serves pair idx*NUM_ADD+j of the current group.
    for (genvar j = 0; j < NUM_ADD; j++) begin : g_add
        int               k;
        logic [IN_W-1:0]  lo, hi;
        assign k          = int'(idx_q) * NUM_ADD + j;
        assign lo         = op_q[(2*k)*IN_W +: IN_W];
        assign hi         = op_q[(2*k+1)*IN_W +: IN_W];
        assign add_sum[j] = {1'b0, lo} + {1'b0, hi};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < NUM_ADD; j++)
                    res_d[(int'(idx_q)*NUM_ADD + j)*SW +: SW] = add_sum[j];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = res_q;

`ifdef ADD_LEVEL_SCHED_STATS_EN
    logic [15:0] job_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_q   <= '0;
            stall_q <= '0;
        end else begin
            if (out_valid && out_ready && job_q != 16'hFFFF)    job_q   <= job_q + 16'd1;
            if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign job_cnt   = job_q;
    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_add_level_sched.sv
// Directed bench for add_level_sched with default parameters (G = 8).
module tb_add_level_sched;
    localparam int IN_W = 5;
    localparam int N_IN = 64;
    localparam int NUM_ADD = 4;
    localparam int SW = IN_W + 1;
    localparam int NS = N_IN / 2;
    localparam int DW = N_IN * IN_W;
    localparam int OW = NS * SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, busy;
    logic [OW-1:0] out_data;
`ifdef ADD_LEVEL_SCHED_STATS_EN
    logic [15:0]   job_cnt, stall_cnt;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_level_sched #(.IN_W(IN_W), .N_IN(N_IN), .NUM_ADD(NUM_ADD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
`ifdef ADD_LEVEL_SCHED_STATS_EN
        , .job_cnt(job_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lane i = (i*a + b) mod 32
    function automatic logic [DW-1:0] pat(input int a, input int b);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < N_IN; i++) p[i*IN_W +: IN_W] = IN_W'((i*a + b) % 32);
        return p;
    endfunction

    function automatic logic [OW-1:0] gold(input logic [DW-1:0] d);
        logic [OW-1:0] g;
        g = '0;
        for (int k = 0; k < NS; k++)
            g[k*SW +: SW] = {1'b0, d[(2*k)*IN_W +: IN_W]} + {1'b0, d[(2*k+1)*IN_W +: IN_W]};
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 99;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, seen, last_acc, nacc, n;
        logic acc;
        logic [OW-1:0] exp_d;
        logic [OW-1:0] q[$];

        // reset
        rst_n = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        step();

        // ramp
        out_ready = 1'b1;
        start_job(pat(1, 0));
        chk("ramp_busy", busy, 1);
        wait_valid(lat);
        chk("ramp_latency", lat, 8);
        chk("ramp_data", out_data, gold(pat(1, 0)));
        chk("ramp_sum0", out_data[0*SW +: SW], 1);
        chk("ramp_sum15", out_data[15*SW +: SW], 61);
        chk("ramp_sum16", out_data[16*SW +: SW], 1);
        chk("ramp_sum31", out_data[31*SW +: SW], 61);
        step();
        chk("ramp_pulse", out_valid, 0);
        chk("ramp_idle", in_ready, 1);

        // max values
        start_job(pat(0, 31));
        wait_valid(lat);
        chk("max_latency", lat, 8);
        chk("max_data", out_data, {32{6'd62}});
        step();

        // backpressure (fresh reset so the counters start from zero)
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        start_job(pat(7, 3));
        wait_valid(lat);
        chk("bp_latency", lat, 8);
        exp_d = gold(pat(7, 3));
        in_valid = 1'b1;
        in_data  = pat(5, 9);
        for (int s = 0; s < 5; s++) begin
            step();
            chk("bp_data", out_data, exp_d);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("bp_drop_valid", out_valid, 0);
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_busy", busy, 0);
`ifdef ADD_LEVEL_SCHED_STATS_EN
        chk("bp_stall_cnt", stall_cnt, 5);
        chk("bp_job_cnt", job_cnt, 1);
`endif

        // reset mid-run
        start_job(pat(3, 1));
        step(); step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", out_data, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_valid", seen, 0);
        start_job(pat(9, 4));
        wait_valid(lat);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_data", out_data, gold(pat(9, 4)));
        step();

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n = 0;
        in_data = pat(11, 1);
        last_acc = -1;
        nacc = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            acc = in_ready;
            step();
            if (acc) begin
                if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, 10);
                last_acc = cyc;
                nacc++;
                q.push_back(gold(in_data));
                n++;
                in_data = pat(11, n*3 + 1);
            end
            if (out_valid) begin
                if (q.size() == 0) chk("b2b_spurious_valid", 1, 0);
                else chk("b2b_data", out_data, q.pop_front());
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            step();
            if (out_valid) chk("b2b_data", out_data, q.pop_front());
        end
        chk("b2b_accepts", nacc, 5);
        chk("b2b_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
